// File: rtl/wb_ram_pipe.sv
// Wishbone B4 pipelined single-port RAM. Memory is cleared by an INIT sweep after reset, then acks arrive LATENCY (1|2) cycles after acceptance.
// Stalls only while clearing. Define WB_RAM_PIPE_ADR_ERR_EN to answer out-of-range addresses with err instead of aliasing.
module wb_ram_pipe #(
  parameter int DW      = 16,
  parameter int DEPTH   = 'h800,
  parameter int AW      = 16,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc,
  input  logic            stb,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW-1:0]   adr,
  input  logic [DW-1:0]   dat_m,
  output logic [DW-1:0]   dat_s,
  output logic            ack,
  output logic            stall,
  output logic            err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [DW-1:0] mem [DEPTH];
  logic [0:0]    state;
  logic [IW-1:0] init_cnt;
  logic [IW-1:0] idx;
  logic          acc;
  logic          bad;
  logic          wr;
  logic          rd;
  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] dat_q;

  assign stall = (state == S_INIT);
  assign acc   = cyc & stb & ~stall;
  assign idx   = adr[IW-1:0];

`ifdef WB_RAM_PIPE_ADR_ERR_EN
  assign bad = |(adr >> IW);
`else
  logic unused_adr;
  assign unused_adr = ^adr;
  assign bad = 1'b0;
`endif

  assign wr = acc & we & ~bad;
  assign rd = acc & ~we & ~bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == IW'(DEPTH - 1)) state <= S_READY;
    end
  end

  // Clearing sweep owns the write port; requests cannot be accepted while it runs.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_INIT) begin
      mem[init_cnt] <= '0;
    end else if (rst_n && wr) begin
      for (int b = 0; b < DW/8; b++) begin
        if (sel[b]) mem[idx][8*b +: 8] <= dat_m[8*b +: 8];
      end
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic          v1;
      logic          e1;
      logic          r1;
      logic [DW-1:0] d1;

      always_ff @(posedge clk) begin
        if (!rst_n || !cyc) begin
          v1    <= 1'b0;
          e1    <= 1'b0;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end else begin
          v1    <= acc & ~bad;
          e1    <= acc & bad;
          ack_q <= v1;
          err_q <= e1;
        end
        r1 <= rd;
        if (rd) d1 <= mem[idx];
        if (v1 && r1) dat_q <= d1;
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n || !cyc) begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end else begin
          ack_q <= acc & ~bad;
          err_q <= acc & bad;
        end
        // dat_s only moves on reads, so it holds the last read word between acks.
        if (rd) dat_q <= mem[idx];
      end
    end
  endgenerate

  assign ack   = ack_q;
  assign err   = err_q;
  assign dat_s = dat_q;

endmodule

// File: tb/tb_wb_ram_pipe.sv
// Bench for wb_ram_pipe: one LATENCY=1 and one LATENCY=2 instance driven by the same bus.
module tb_wb_ram_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [15:0] adr = '0;
  logic [15:0] dat_m = '0;
  logic [15:0] dat_s1, dat_s2;
  logic        ack1, ack2, stall1, stall2, err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ram_pipe #(.DW(16), .DEPTH('h800), .AW(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .adr(adr), .dat_m(dat_m), .dat_s(dat_s1), .ack(ack1), .stall(stall1), .err(err1));

  wb_ram_pipe #(.DW(16), .DEPTH('h800), .AW(16), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
    .adr(adr), .dat_m(dat_m), .dat_s(dat_s2), .ack(ack2), .stall(stall2), .err(err2));

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [15:0] exp_dat;
  } vec_t;

`ifdef WB_RAM_PIPE_ADR_ERR_EN
  localparam logic        RNG_ACK = 1'b0;
  localparam logic        RNG_ERR = 1'b1;
  localparam logic [15:0] W0_EXP  = 16'h0000;
`else
  localparam logic        RNG_ACK = 1'b1;
  localparam logic        RNG_ERR = 1'b0;
  localparam logic [15:0] W0_EXP  = 16'h1234;
`endif

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    stb = 1'b0;
    we  = 1'b0;
    sel = 2'b00;
  endtask

  // Single request; caller sits just after a clock edge.
  task automatic xfer(input vec_t v, input string nm);
    cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; dat_m = v.dat;
    @(posedge clk); #1;
    idle_bus();
    chk({nm, " ack1"}, ack1, v.exp_ack);
    chk({nm, " err1"}, err1, v.exp_err);
    chk({nm, " ack2 early"}, ack2, 1'b0);
    if (!v.we && v.exp_ack) chk({nm, " dat1"}, dat_s1, v.exp_dat);
    @(posedge clk); #1;
    chk({nm, " ack2"}, ack2, v.exp_ack);
    chk({nm, " err2"}, err2, v.exp_err);
    chk({nm, " ack1 single"}, ack1, 1'b0);
    if (!v.we && v.exp_ack) begin
      chk({nm, " dat2"}, dat_s2, v.exp_dat);
      chk({nm, " dat1 hold"}, dat_s1, v.exp_dat);
    end
  endtask

  task automatic count_init(input string nm);
    int n;
    n = 0;
    while (stall1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " stall cycles"}, n, 2048);
    chk({nm, " stall2"}, stall2, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 2'b11, 16'h07FF, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 2'b11, 16'h0005, 16'hABCD, 1'b1, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 2'b01, 16'h0005, 16'h0012, 1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hAB12};
    vecs[5]  = '{1'b1, 2'b00, 16'h0005, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'hAB12};
    vecs[7]  = '{1'b1, 2'b10, 16'h0005, 16'h3400, 1'b1, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h3412};
    vecs[9]  = '{1'b1, 2'b11, 16'h0800, 16'h1234, RNG_ACK, RNG_ERR, 16'h0000};
    vecs[10] = '{1'b0, 2'b11, 16'h0000, 16'h0000, 1'b1, 1'b0, W0_EXP};
    vecs[11] = '{1'b0, 2'b11, 16'h0805, 16'h0000, RNG_ACK, RNG_ERR, 16'h3412};

    repeat (2) @(posedge clk);
    #1;
    chk("rst stall1", stall1, 1'b1);
    chk("rst stall2", stall2, 1'b1);
    chk("rst ack1", ack1, 1'b0);
    chk("rst ack2", ack2, 1'b0);
    chk("rst err1", err1, 1'b0);
    chk("rst err2", err2, 1'b0);
    rst_n = 1'b1;
    count_init("init");

    for (int k = 0; k < 12; k++) xfer(vecs[k], $sformatf("v%0d", k));

    // Back-to-back: 4 writes then 4 reads, stb held for 8 cycles.
    cyc = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        stb = 1'b1; we = (t < 4); sel = 2'b11;
        adr = 16'(t % 4 + 1);
        dat_m = 16'(16'h11 * (t % 4 + 1));
      end else begin
        idle_bus();
      end
      @(posedge clk); #1;
      chk($sformatf("pipe ack1 s%0d", t), ack1, (t < 8));
      chk($sformatf("pipe ack2 s%0d", t), ack2, (t >= 1 && t < 9));
      if (t >= 4 && t < 8) chk($sformatf("pipe dat1 s%0d", t), dat_s1, 16'h11 * (t - 3));
      if (t >= 5 && t < 9) chk($sformatf("pipe dat2 s%0d", t), dat_s2, 16'h11 * (t - 4));
    end

    // Read-after-write on consecutive cycles.
    stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0007; dat_m = 16'h5A5A;
    @(posedge clk); #1;
    we = 1'b0; dat_m = 16'h0000;
    @(posedge clk); #1;
    idle_bus();
    chk("raw dat1", dat_s1, 16'h5A5A);
    chk("raw ack1", ack1, 1'b1);
    @(posedge clk); #1;
    chk("raw dat2", dat_s2, 16'h5A5A);
    chk("raw ack2", ack2, 1'b1);
    @(posedge clk); #1;

    // Dropping cyc flushes the pending LATENCY=2 ack but the write still lands.
    stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0009; dat_m = 16'h7777;
    @(posedge clk); #1;
    idle_bus();
    cyc = 1'b0;
    chk("flush ack1", ack1, 1'b1);
    @(posedge clk); #1;
    chk("flush ack2", ack2, 1'b0);
    chk("flush err2", err2, 1'b0);
    cyc = 1'b1;
    xfer('{1'b0, 2'b11, 16'h0009, 16'h0000, 1'b1, 1'b0, 16'h7777}, "flush rd9");

    // Reset mid-INIT at init_cnt=100 restarts the full sweep.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid stall pre", stall1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid rst stall", stall1, 1'b1);
    chk("mid rst ack1", ack1, 1'b0);
    rst_n = 1'b1;
    count_init("reinit");
    xfer('{1'b0, 2'b11, 16'h0032, 16'h0000, 1'b1, 1'b0, 16'h0000}, "clr w50");
    xfer('{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0000}, "clr w5");
    xfer('{1'b0, 2'b11, 16'h0007, 16'h0000, 1'b1, 1'b0, 16'h0000}, "clr w7");
    xfer('{1'b0, 2'b11, 16'h0009, 16'h0000, 1'b1, 1'b0, 16'h0000}, "clr w9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
